// File: rtl/adder_pkg.sv
// Shared constants for the bit-serial adder: state encoding and default width.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, used as the shared slice of the serial adder.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic cout_o
);

    // Sum and carry of three input bits.
    always_comb begin
        sum_o  = a_i ^ b_i ^ c_i;
        cout_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full_adder slice reused over WIDTH cycles, LSB first,
// with a start/busy/done handshake. {cout,sum} = a + b + cin.
module serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum;
    logic             fa_cout;

    // The one shared bit slice: current LSBs plus the running carry.
    full_adder u_fa (
        .a_i    (ra_q[0]),
        .b_i    (rb_q[0]),
        .c_i    (cy_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    // Next-state and datapath update; busy/done are precomputed so they leave a flop.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    cy_d    = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                sum_d = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                cy_d  = fa_cout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
